rgb_yuv_sched: RTL and testbench
================================

# rgb_yuv_sched

Line-granular round-robin scheduler that shares one `rgb_yuv` converter between `NCH` independent RGB pixel streams. The converter is a fixed-latency, non-stallable pipeline with no valid signal. This block therefore owns the valid/tag tracking through that pipeline, and uses credit-based flow control so results never overflow the output buffer. It sits between the per-camera RGB sources and the downstream YUV consumer; the converter instance sits beside it at the same hierarchy level.

## Interface
Parameters:
- `NCH`, 2: number of requesting RGB streams, 2..8.
- `LAT`, 8: converter latency in cycles, from `conv_r/g/b` change to the matching `conv_y/u/v`.
- `FDEPTH`, 16: output FIFO depth, power of 2, ≥ `LAT`+2.

Ports:
- `clock` in 1: single clock; every register in the block is clocked on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in NCH: per-stream pixel valid.
- `s_ready` out NCH: per-stream accept; at most one bit is set per cycle.
- `s_rgb` in NCH*48: per-stream `{r,g,b}`, 16 bits each; stream k occupies bits [48k+:48].
- `s_last` in NCH: last pixel of a line.
- `conv_r`, `conv_g`, `conv_b` out 16 each: registered pixel driven to the converter.
- `conv_y`, `conv_u`, `conv_v` in 16 each: converter results.
- `m_valid` out 1: output valid.
- `m_ready` in 1: output accept.
- `m_yuv` out 48: `{y,u,v}`.
- `m_ch` out clog2(NCH): source stream index.
- `m_last` out 1: end-of-line marker, propagated from `s_last`.

## Operation
- Issue: stream k handshakes when `s_valid[k] & s_ready[k]`. On that edge, `conv_r/g/b` load `s_rgb[k]`, and tag `{1, k, s_last[k]}` enters the tag delay line.
- Between issues, `conv_r/g/b` hold their value, and a zero (invalid) tag enters the delay line.
- Tag delay: the tag is delayed so that it arrives exactly in the cycle the matching `conv_y/u/v` are present. The FIFO write `{conv_y,conv_u,conv_v,ch,last}` happens on edge E0+`LAT`+1, where E0 is the issue edge. Invalid tags write nothing.
- Credit: `inflight` counts issued-but-not-written pixels. Issue is permitted only when `fifo_count + inflight < FDEPTH`, evaluated on registered counts, so a pop in the same cycle frees credit only from the next cycle. The FIFO therefore can never overflow.
- FSM:
  - ARB: pick the first k with `s_valid[k]`, scanning from `rr_ptr`. Register the grant, then go to BURST. No issue happens in ARB, so each line costs one bubble cycle.
  - BURST: `s_ready[grant] = credit_ok`, all other `s_ready` bits are 0.
  - On an accepted pixel with `s_last` set: `rr_ptr <= grant+1` (mod NCH), then go to ARB.
  - A stream that drops `s_valid` mid-line keeps the grant; the line is never preempted.
- `inflight`: +1 on issue, −1 on FIFO write. Both in the same cycle leave it unchanged.
- Output: first-word-fall-through FIFO. `m_valid` = not empty. Pop on `m_valid & m_ready`. Push and pop in the same cycle are allowed at any fill level, including full (the credit rule guarantees a write never targets a full FIFO without a pop).

## Timing
- Reset values: FSM=ARB, `rr_ptr`=0, grant=0, `inflight`=0, all tags invalid, FIFO empty. Outputs: `s_ready`=0, `m_valid`=0, `m_yuv`=0, `m_ch`=0, `m_last`=0, `conv_r/g/b`=0.
- Reset mid-operation discards all in-flight and buffered pixels. Converter outputs arriving after reset are ignored because their tags are cleared.
- Best-case latency from `s_valid` rise (in ARB, with credit) to `m_valid` rise: 1 (ARB) + 1 (issue) + `LAT`+1 (write) = `LAT`+3 cycles.
- Sustained throughput is 1 pixel/cycle inside a line, provided `m_ready`=1 and `FDEPTH` ≥ `LAT`+2.
- `m_ready` held low: the FIFO fills, issue stops with `inflight`=0 and `fifo_count`=`FDEPTH`, and no pixel is lost. The first pop re-enables issue one cycle later.
- `rr_ptr` wraps from NCH−1 to 0.

## Structure
- Shared package `rgb_yuv_pkg`:
  - `RGB_YUV_LAT` = 8, the converter latency constant, also used as the `LAT` default.
  - Tag struct `{valid, ch, last}`.
  - FSM enum `{ARB, BURST}`.
- Sub-module `yuv_out_fifo`: a synchronous FWFT FIFO parameterised by depth and width, exposing `count`.
- The tag delay line is an inline shift register in the top block.

## Test plan
- Single stream, NCH=2: stream 0 sends a 4-pixel line with R=G=B=0x8000 and `m_ready`=1 → 4 outputs with `m_ch`=0 and Y=0x7FFF±1. `m_last` is set on the 4th output only. The first `m_valid` appears `LAT`+3 cycles after `s_valid` rises.
- Contention: both streams continuously valid, lines of 3 pixels → output lines alternate 0,1,0,1. Lines never interleave. There is exactly 1 idle issue cycle between lines.
- Backpressure: `m_ready`=0 for 40 cycles while stream 1 streams → `fifo_count` saturates at 16, `s_ready` drops, `inflight` reaches 0. After `m_ready` is released, all pixels arrive in order with none lost or duplicated.
- Random mix: random `s_valid`/`m_ready` over 1000 pixels with a reference converter model → the output sequence per `m_ch` matches the model exactly.
- Reset mid-burst: assert `rst` for 1 cycle with 5 pixels in flight → outputs take their reset values on the next cycle. No stale pixel appears afterwards. The next line starts at stream 0.
- Wrap: NCH=3, only stream 2 active → `rr_ptr` wraps to 0 and stream 2 is regranted without extra idle cycles beyond the ARB bubble.

Source files
------------

// File: rtl/rgb_yuv_pkg.sv
// Shared constants and types for the RGB->YUV converter and the stream scheduler
// that time-shares it.
package rgb_yuv_pkg;

  localparam int unsigned RGB_YUV_LAT = 8;
  localparam int unsigned TAG_CH_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
    logic                last;
  } tag_t;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } sched_state_e;

  // (base + off) mod n, for base < n and off <= n
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/yuv_out_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; dout reads as
// zero while empty so the block outputs have defined reset values.
module yuv_out_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    // a push into a full FIFO is accepted only alongside a pop
    do_push  = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rgb_yuv_sched.sv
// Line-granular round-robin scheduler sharing one fixed-latency rgb_yuv converter
// between NCH RGB streams, with tag tracking and credit-based output flow control.
module rgb_yuv_sched
  import rgb_yuv_pkg::*;
#(
  parameter  int unsigned NCH    = 2,
  parameter  int unsigned LAT    = RGB_YUV_LAT,
  parameter  int unsigned FDEPTH = 16,
  localparam int unsigned CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [NCH-1:0]    s_valid,
  output logic [NCH-1:0]    s_ready,
  input  logic [NCH*48-1:0] s_rgb,
  input  logic [NCH-1:0]    s_last,
  output logic [15:0]       conv_r,
  output logic [15:0]       conv_g,
  output logic [15:0]       conv_b,
  input  logic [15:0]       conv_y,
  input  logic [15:0]       conv_u,
  input  logic [15:0]       conv_v,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [47:0]       m_yuv,
  output logic [CW-1:0]     m_ch,
  output logic              m_last
);

  localparam int unsigned CNT_W = $clog2(FDEPTH) + 1;
  localparam int unsigned FW    = 48 + CW + 1;

  sched_state_e     state_q, state_d;
  logic [CW-1:0]    grant_q, grant_d;
  logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] fifo_count;
  logic [47:0]      conv_rgb_q, conv_rgb_d;
  tag_t             tag_q [LAT+1];
  tag_t             tag_d;

  logic [47:0]      sel_rgb;
  logic             sel_valid, sel_last;
  logic             credit_ok, issue, found, wr_en, pop, fifo_empty;
  logic [FW-1:0]    fifo_din, fifo_dout;

  always_comb begin
    sel_rgb   = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (CW'(k) == grant_q) begin
        sel_rgb   = s_rgb[48*k +: 48];
        sel_valid = s_valid[k];
        sel_last  = s_last[k];
      end
    end
  end

  // Credit uses registered counts only, so a pop frees a slot one cycle later.
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CNT_W+1)'(FDEPTH);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    s_ready  = '0;
    issue    = 1'b0;
    found    = 1'b0;
    case (state_q)
      ARB: begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (!found && s_valid[rr_index(32'(rr_ptr_q), i, NCH)]) begin
            found   = 1'b1;
            grant_d = CW'(rr_index(32'(rr_ptr_q), i, NCH));
          end
        end
        if (found) begin
          state_d = BURST;
        end
      end
      BURST: begin
        s_ready[grant_q] = credit_ok;
        issue            = sel_valid && credit_ok;
        if (issue && sel_last) begin
          rr_ptr_d = CW'(rr_index(32'(grant_q), 1, NCH));
          state_d  = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Tag stage LAT lines up with the converter output for the pixel issued LAT+1 edges ago.
  always_comb begin
    tag_d      = issue ? '{valid: 1'b1, ch: TAG_CH_W'(grant_q), last: sel_last} : '0;
    conv_rgb_d = issue ? sel_rgb : conv_rgb_q;
    wr_en      = tag_q[LAT].valid;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(wr_en);
    fifo_din   = {conv_y, conv_u, conv_v, tag_q[LAT].ch[CW-1:0], tag_q[LAT].last};
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ARB;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      inflight_q <= '0;
      conv_rgb_q <= '0;
      for (int unsigned i = 0; i <= LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      inflight_q <= inflight_d;
      conv_rgb_q <= conv_rgb_d;
      tag_q[0]   <= tag_d;
      for (int unsigned i = 1; i <= LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign conv_r = conv_rgb_q[47:32];
  assign conv_g = conv_rgb_q[31:16];
  assign conv_b = conv_rgb_q[15:0];

  yuv_out_fifo #(
    .DEPTH (FDEPTH),
    .WIDTH (FW)
  ) u_out_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (wr_en),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_yuv   = fifo_dout[FW-1 -: 48];
  assign m_ch    = fifo_dout[1 +: CW];
  assign m_last  = fifo_dout[0];

endmodule

// File: tb/tb_rgb_yuv_sched.sv
// Scoreboard bench for rgb_yuv_sched with a behavioural fixed-latency converter beside it.
module tb_rgb_yuv_sched;
  import rgb_yuv_pkg::*;

  localparam int unsigned NCH    = 2;
  localparam int unsigned LAT    = RGB_YUV_LAT;
  localparam int unsigned FDEPTH = 16;

  typedef struct packed {
    logic [47:0] yuv;
    logic        ch;
    logic        last;
  } exp_t;

  typedef struct {
    int   cyc;
    int   ch;
    logic last;
  } hs_t;

  logic              clock = 1'b0;
  logic              rst   = 1'b1;
  logic [NCH-1:0]    s_valid, s_ready, s_last;
  logic [NCH*48-1:0] s_rgb;
  logic [15:0]       conv_r, conv_g, conv_b, conv_y, conv_u, conv_v;
  logic              m_valid, m_ready, m_last;
  logic [47:0]       m_yuv;
  logic [0:0]        m_ch;

  exp_t        sb[$];
  exp_t        out_log[$];
  hs_t         hs_log[$];
  logic [48:0] stim_q [NCH][$];
  logic [NCH-1:0] en = '0;
  int unsigned vpct = 100;
  int unsigned mpct = 100;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int first_mv = -1;

  rgb_yuv_sched #(
    .NCH    (NCH),
    .LAT    (LAT),
    .FDEPTH (FDEPTH)
  ) dut (
    .clock   (clock),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_rgb   (s_rgb),
    .s_last  (s_last),
    .conv_r  (conv_r),
    .conv_g  (conv_g),
    .conv_b  (conv_b),
    .conv_y  (conv_y),
    .conv_u  (conv_u),
    .conv_v  (conv_v),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_yuv   (m_yuv),
    .m_ch    (m_ch),
    .m_last  (m_last)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference converter: simple shift-based transform, result valid LAT cycles later.
  function automatic logic [47:0] conv_f(input logic [47:0] rgb);
    logic [15:0] r, g, b, y, u, v;
    {r, g, b} = rgb;
    y = (r >> 2) + (g >> 1) + (b >> 2);
    u = (b >> 1) - (y >> 1) + 16'h8000;
    v = (r >> 1) - (y >> 1) + 16'h8000;
    return {y, u, v};
  endfunction

  logic [47:0] cpipe [LAT];
  always @(posedge clock) begin
    cpipe[0] <= conv_f({conv_r, conv_g, conv_b});
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign {conv_y, conv_u, conv_v} = cpipe[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Driver: present stream heads at negedge, record handshakes that the next posedge takes.
  initial begin
    logic [48:0] item;
    s_valid = '0;
    s_rgb   = '0;
    s_last  = '0;
    m_ready = 1'b0;
    forever begin
      @(negedge clock);
      for (int k = 0; k < NCH; k++) begin
        if (en[k] && stim_q[k].size() != 0 && $urandom_range(99) < vpct) begin
          item              = stim_q[k][0];
          s_valid[k]        = 1'b1;
          s_rgb[48*k +: 48] = item[48:1];
          s_last[k]         = item[0];
        end else begin
          s_valid[k]        = 1'b0;
          s_rgb[48*k +: 48] = '0;
          s_last[k]         = 1'b0;
        end
      end
      m_ready = ($urandom_range(99) < mpct);
      #1;
      if (!rst) begin
        for (int k = 0; k < NCH; k++) begin
          if (s_valid[k] && s_ready[k]) begin
            item = stim_q[k].pop_front();
            sb.push_back('{yuv: conv_f(item[48:1]), ch: 1'(k), last: item[0]});
            hs_log.push_back('{cyc: cyc, ch: k, last: item[0]});
          end
        end
      end
    end
  end

  // Monitor: pop the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (!rst && m_valid) begin
        if (first_mv < 0) first_mv = cyc;
        if (m_ready) begin
          out_log.push_back('{yuv: m_yuv, ch: m_ch, last: m_last});
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out: got yuv=%h ch=%0d last=%0d, required no output",
                     m_yuv, m_ch, m_last);
          end else begin
            e = sb.pop_front();
            if ({m_yuv, m_ch, m_last} !== e) begin
              n_bad++;
              $display("FAIL out_word: got yuv=%h ch=%0d last=%0d, required yuv=%h ch=%0d last=%0d",
                       m_yuv, m_ch, m_last, e.yuv, e.ch, e.last);
            end
          end
        end
      end
    end
  end

  function automatic bit all_idle();
    for (int k = 0; k < NCH; k++) if (stim_q[k].size() != 0) return 1'b0;
    return (sb.size() == 0) && !m_valid;
  endfunction

  task automatic wait_drain(input string name, input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && !all_idle()) begin
      @(negedge clock);
      #3;
      n++;
    end
    if (n >= max_cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got still busy after %0d cycles, required drained", name, n);
    end
  endtask

  task automatic load_line(input int k, input int n, input int line_id);
    for (int i = 0; i < n; i++)
      stim_q[k].push_back({16'(k + 1), 16'(line_id), 16'(i), (i == n - 1)});
  endtask

  task automatic start_at_edge();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int t0;
    logic stale;
    logic [48:0] px;

    // reset values
    repeat (3) @(negedge clock);
    #2;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_yuv", 64'(m_yuv), 64'(0));
    check("rst_m_ch_last", 64'({m_ch, m_last}), 64'(0));
    check("rst_conv", 64'({conv_r, conv_g, conv_b}), 64'(0));
    @(negedge clock);
    rst = 1'b0;

    // single stream, grey line, latency
    start_at_edge();
    out_log.delete();
    for (int i = 0; i < 4; i++) stim_q[0].push_back({48'h8000_8000_8000, (i == 3)});
    first_mv = -1;
    t0 = cyc;
    en = 2'b01;
    wait_drain("single", 200);
    check("lat_first_valid", 64'(first_mv - t0), 64'(LAT + 3));
    check("single_count", 64'(out_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < out_log.size(); i++) begin
      check("single_yuv", 64'(out_log[i].yuv), 64'h8000_8000_8000);
      check("single_ch", 64'(out_log[i].ch), 64'(0));
      check("single_last", 64'(out_log[i].last), 64'(i == 3));
    end

    // contention: rr_ptr now 1, so lines go 1,0,1,0,...
    start_at_edge();
    hs_log.delete();
    for (int j = 0; j < 4; j++) begin
      load_line(0, 3, j);
      load_line(1, 3, j);
    end
    en = 2'b11;
    wait_drain("contention", 400);
    check("cont_hs_count", 64'(hs_log.size()), 64'(24));
    for (int i = 0; i < 24 && i < hs_log.size(); i++) begin
      check("cont_line_ch", 64'(hs_log[i].ch), 64'(((i / 3) + 1) % 2));
      if (i > 0)
        check("cont_gap", 64'(hs_log[i].cyc - hs_log[i-1].cyc), 64'((i % 3 == 0) ? 2 : 1));
    end

    // backpressure on stream 1
    start_at_edge();
    out_log.delete();
    for (int j = 0; j < 3; j++) load_line(1, 10, j);
    mpct = 0;
    en = 2'b10;
    repeat (40) @(negedge clock);
    #3;
    check("bp_fifo_full", 64'(dut.fifo_count), 64'(FDEPTH));
    check("bp_inflight", 64'(dut.inflight_q), 64'(0));
    check("bp_s_ready", 64'(s_ready), 64'(0));
    mpct = 100;
    wait_drain("backpressure", 400);
    check("bp_out_count", 64'(out_log.size()), 64'(30));

    // wrap: stream 1 alone is regranted after each ARB bubble
    start_at_edge();
    hs_log.delete();
    for (int j = 0; j < 3; j++) load_line(1, 2, j);
    en = 2'b10;
    wait_drain("wrap", 200);
    check("wrap_hs_count", 64'(hs_log.size()), 64'(6));
    for (int i = 1; i < 6 && i < hs_log.size(); i++)
      check("wrap_gap", 64'(hs_log[i].cyc - hs_log[i-1].cyc), 64'((i % 2 == 0) ? 2 : 1));

    // reset mid-burst on stream 1 (rr_ptr left at 1 by a stream-0 line)
    start_at_edge();
    load_line(0, 2, 0);
    en = 2'b01;
    wait_drain("pre_reset", 200);
    start_at_edge();
    hs_log.delete();
    load_line(1, 10, 7);
    en = 2'b10;
    for (int n = 0; n < 50 && hs_log.size() < 5; n++) begin
      @(negedge clock);
      #2;
    end
    check("rst_mid_issued", 64'(hs_log.size()), 64'(5));
    @(negedge clock);
    rst = 1'b1;
    en  = '0;
    sb.delete();
    for (int k = 0; k < NCH; k++) stim_q[k].delete();
    @(negedge clock);
    rst = 1'b0;
    #2;
    check("mid_rst_m_valid", 64'(m_valid), 64'(0));
    check("mid_rst_s_ready", 64'(s_ready), 64'(0));
    check("mid_rst_m_word", 64'({m_yuv, m_ch, m_last}), 64'(0));
    check("mid_rst_conv", 64'({conv_r, conv_g, conv_b}), 64'(0));
    stale = 1'b0;
    repeat (20) begin
      @(negedge clock);
      #2;
      stale = stale | m_valid;
    end
    check("mid_rst_no_stale", 64'(stale), 64'(0));
    start_at_edge();
    hs_log.delete();
    load_line(0, 2, 8);
    load_line(1, 2, 8);
    en = 2'b11;
    wait_drain("post_reset", 200);
    check("post_rst_first_ch", 64'((hs_log.size() > 0) ? hs_log[0].ch : -1), 64'(0));

    // random mix: 500 pixels per stream, random line lengths and handshakes
    start_at_edge();
    out_log.delete();
    for (int k = 0; k < NCH; k++) begin
      int left;
      left = 500;
      while (left > 0) begin
        int len;
        len = int'($urandom_range(8, 1));
        if (len > left) len = left;
        for (int i = 0; i < len; i++) begin
          px = {16'($urandom), 16'($urandom), 16'($urandom), (i == len - 1)};
          stim_q[k].push_back(px);
        end
        left -= len;
      end
    end
    vpct = 75;
    mpct = 70;
    en = 2'b11;
    wait_drain("random", 20000);
    check("rand_out_count", 64'(out_log.size()), 64'(1000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
